// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, FSM state type and instruction field positions
//
// Purpose : definitions shared by the control sequencer and its interface.
// Ports   : none (package).
package ctrl_pkg;

  // Opcode values, instr[15:12]
  localparam logic [3:0] OPC_NOP        = 4'h0;
  localparam logic [3:0] OPC_MOV        = 4'h1;
  localparam logic [3:0] OPC_ADD        = 4'h2;
  localparam logic [3:0] OPC_SUB        = 4'h3;
  localparam logic [3:0] OPC_AND        = 4'h4;
  localparam logic [3:0] OPC_OR         = 4'h5;
  localparam logic [3:0] OPC_XOR        = 4'h6;
  localparam logic [3:0] OPC_LDI        = 4'h7;
  localparam logic [3:0] OPC_JMP        = 4'h8;
  localparam logic [3:0] OPC_JZ_DEFAULT = 4'h9;
  localparam logic [3:0] OPC_HALT       = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  // Instruction field positions
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int DEST_MSB = 11;
  localparam int DEST_LSB = 8;
  localparam int SRCA_MSB = 7;
  localparam int SRCA_LSB = 4;
  localparam int SRCB_MSB = 3;
  localparam int SRCB_LSB = 0;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction memory fetch bus
//
// Purpose : groups the instruction fetch handshake.
// Signals : imem_req   - fetch request (sequencer -> memory)
//           imem_addr  - fetch address, PC_WIDTH bits (sequencer -> memory)
//           imem_ack   - instruction valid this cycle (memory -> sequencer)
//           instr      - 16-bit instruction word (memory -> sequencer)
interface control_sequencer_if #(
  parameter int PC_WIDTH = 8
) ();

  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [15:0]         instr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  instr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output instr
  );

endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute/writeback control sequencer
//
// Purpose : multi-cycle FSM that fetches 16-bit instructions, drives register
//           file / ALU selects, sequences the PC (jumps, conditional jumps,
//           wrap-around increment) and stops in HALT until reset.
// Optional: SINGLE_STEP_EN - adds the step input; each fetch waits for a step
//           pulse seen since FETCH was entered.
// Ports   : clk, reset       - clock, synchronous active-high reset
//           imem             - fetch bus (master side)
//           step             - single-step pulse (SINGLE_STEP_EN only)
//           zero             - ALU zero flag, used by JZ in EXEC
//           dest_sel, src_a_sel, src_b_sel, alu_op, imm, imm_sel
//                            - decoded controls, held from DECODE to next DECODE
//           wr_en            - register write strobe, high only in WB
//           halted           - high in HALT
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int         PC_WIDTH = 8,
  parameter logic [3:0] OPC_JZ   = OPC_JZ_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  control_sequencer_if.master   imem,
`ifdef SINGLE_STEP_EN
  input  logic                  step,
`endif
  input  logic                  zero,
  output logic [3:0]            dest_sel,
  output logic [3:0]            src_a_sel,
  output logic [3:0]            src_b_sel,
  output logic [3:0]            alu_op,
  output logic [7:0]            imm,
  output logic                  imm_sel,
  output logic                  wr_en,
  output logic                  halted
);

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt, pc_inc, pc_imm;
  logic [15:0]         ir;
  logic [3:0]          opcode;
  logic                fetch_ok;
  logic                req;
  logic                accept;

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign pc_inc = pc + PC_WIDTH'(1);
  assign pc_imm = PC_WIDTH'(ir[IMM_MSB:IMM_LSB]);
  assign accept = req && imem.imem_ack;

`ifdef SINGLE_STEP_EN
  // Cleared whenever we are away from FETCH, so only a step seen after
  // FETCH entry can release the next request.
  logic step_seen;
  always_ff @(posedge clk) begin
    if (reset) begin
      step_seen <= 1'b0;
    end else if (state != ST_FETCH) begin
      step_seen <= 1'b0;
    end else if (step) begin
      step_seen <= 1'b1;
    end
  end
  assign fetch_ok = step_seen;
`else
  assign fetch_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    req       = 1'b0;
    wr_en     = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_FETCH: begin
        req = fetch_ok;
        if (req && imem.imem_ack) state_nxt = ST_DECODE;
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        // JZ is tested first because its opcode is a parameter.
        if (opcode == OPC_JZ) begin
          pc_nxt    = zero ? pc_imm : pc_inc;
          state_nxt = ST_FETCH;
        end else begin
          case (opcode)
            OPC_MOV, OPC_ADD, OPC_SUB, OPC_AND,
            OPC_OR, OPC_XOR, OPC_LDI: state_nxt = ST_WB;
            OPC_JMP: begin
              pc_nxt    = pc_imm;
              state_nxt = ST_FETCH;
            end
            OPC_HALT: state_nxt = ST_HALT;
            default: begin
              // NOP and the unassigned opcodes
              pc_nxt    = pc_inc;
              state_nxt = ST_FETCH;
            end
          endcase
        end
      end
      ST_WB: begin
        wr_en     = 1'b1;
        pc_nxt    = pc_inc;
        state_nxt = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Decoded fields are captured on the same edge that loads IR, so they are
  // valid from the DECODE cycle and hold until the next accepted fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      ir        <= '0;
      dest_sel  <= '0;
      src_a_sel <= '0;
      src_b_sel <= '0;
      alu_op    <= '0;
      imm       <= '0;
      imm_sel   <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (accept) begin
        ir        <= imem.instr;
        dest_sel  <= imem.instr[DEST_MSB:DEST_LSB];
        src_a_sel <= imem.instr[SRCA_MSB:SRCA_LSB];
        src_b_sel <= imem.instr[SRCB_MSB:SRCB_LSB];
        alu_op    <= imem.instr[OPC_MSB:OPC_LSB];
        imm       <= imem.instr[IMM_MSB:IMM_LSB];
        imm_sel   <= (imem.instr[OPC_MSB:OPC_LSB] == OPC_LDI);
      end
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

endmodule
